// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the Dmem port arbiter: state encoding, default widths
// and a small port-to-one-hot helper.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 128;
  localparam int TIMEOUT_DEF = 255;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; the caller owns the 'last' register.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       any_o
);

  // On a tie the port that did not win last time goes first.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the Dmem block port between the D-cache refill path (port 0) and the
// writeback drain (port 1), sequencing ren/wen/ready/done with a watchdog.
//
// state   | meaning
// IDLE    | wait for mem_ready and a request, pick and latch the winner
// BUSY    | strobe held to Dmem, counting toward the abort limit
// RELEASE | wait until Dmem is idle again before the next arbitration
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              p0_req_i,
  input  logic              p0_wen_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_done_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_wen_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_done_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic              mem_ready_i,
  input  logic              mem_done_i,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic              timeout_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              op_q, op_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              err_q, err_d;

  logic [1:0] arb_gnt;
  logic       arb_any;

  rr_arb2 u_rr_arb2 (
    .req_i  ({p1_req_i, p0_req_i}),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .any_o  (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win_d    = win_q;
    op_d     = op_q;
    strobe_d = strobe_q;
    addr_d   = addr_q;
    din_d    = din_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_ready_i && arb_any) begin
          win_d   = arb_gnt[1];
          last_d  = arb_gnt[1];
          gnt_d   = arb_gnt;
          addr_d  = arb_gnt[1] ? p1_addr_i  : p0_addr_i;
          din_d   = arb_gnt[1] ? p1_wdata_i : p0_wdata_i;
          op_d    = arb_gnt[1] ? p1_wen_i   : p0_wen_i;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Strobe rises one cycle after the grant pulse.
        if (!strobe_q) begin
          strobe_d = 1'b1;
        end
        if (strobe_q && mem_done_i) begin
          if (!op_q) begin
            if (win_q) rdata1_d = mem_dout_i;
            else       rdata0_d = mem_dout_i;
          end
          done_d   = port_onehot(win_q);
          strobe_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RELEASE;
        end else if (cnt_q == CNT_LIMIT) begin
          err_d    = 1'b1;
          done_d   = port_onehot(win_q);
          strobe_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (mem_ready_i && !mem_done_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        strobe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      op_q     <= 1'b0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
      op_q     <= op_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
    end
  end

  assign mem_ren_o     = strobe_q & ~op_q;
  assign mem_wen_o     = strobe_q &  op_q;
  assign mem_addr_o    = addr_q;
  assign mem_din_o     = din_q;
  assign p0_gnt_o      = gnt_q[0];
  assign p1_gnt_o      = gnt_q[1];
  assign p0_done_o     = done_q[0];
  assign p1_done_o     = done_q[1];
  assign p0_rdata_o    = rdata0_q;
  assign p1_rdata_o    = rdata1_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: requester agents, a Dmem responder and an event-level
// reference model watching grants, strobes, completions and read data.
module tb_dmem_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 128;
  localparam int TB_TO = 120;
  localparam int LIM   = 700;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req [2];
  logic          wen [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic          p0_gnt, p1_gnt, p0_done, p1_done;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_ren, mem_wen, mem_ready, mem_done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [1:0]    gnt, done;

  assign gnt  = {p1_gnt, p0_gnt};
  assign done = {p1_done, p0_done};

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TB_TO)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .p0_req_i(req[0]), .p0_wen_i(wen[0]), .p0_addr_i(addr[0]), .p0_wdata_i(wdata[0]),
    .p0_gnt_o(p0_gnt), .p0_done_o(p0_done), .p0_rdata_o(rdata0),
    .p1_req_i(req[1]), .p1_wen_i(wen[1]), .p1_addr_i(addr[1]), .p1_wdata_i(wdata[1]),
    .p1_gnt_o(p1_gnt), .p1_done_o(p1_done), .p1_rdata_o(rdata1),
    .mem_ren_o(mem_ren), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
    .mem_ready_i(mem_ready), .mem_done_i(mem_done), .mem_dout_i(mem_dout),
    .timeout_err_o(err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Dmem responder: acts on the first cycle a strobe is seen
  int             lat_fixed = 2;
  bit             rand_lat = 0, rand_ready = 0, never_done = 0;
  logic [DW-1:0]  dmem [logic [AW-1:0]];
  bit             pending = 0;
  int             left = 0;
  logic           strobe_prev = 1'b0;
  logic           pend_read = 1'b0;
  logic [AW-1:0]  pend_addr = '0;

  initial begin
    mem_ready = 1'b1;
    mem_done  = 1'b0;
    mem_dout  = '0;
    forever begin
      @(posedge clk); #1;
      mem_done  = 1'b0;
      mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!rst_n) begin
        pending     = 0;
        strobe_prev = 1'b0;
      end else begin
        if ((mem_ren || mem_wen) && !strobe_prev) begin
          if (mem_wen) dmem[mem_addr] = mem_din;
          if (!never_done) begin
            pending   = 1;
            left      = rand_lat ? $urandom_range(0, 5) : lat_fixed - 1;
            pend_read = mem_ren;
            pend_addr = mem_addr;
          end
        end
        strobe_prev = mem_ren || mem_wen;
        if (pending) begin
          if (left == 0) begin
            mem_done = 1'b1;
            mem_dout = (pend_read && dmem.exists(pend_addr)) ? dmem[pend_addr]
                                                             : {$urandom, $urandom, $urandom, $urandom};
            pending  = 0;
          end else begin
            left--;
          end
        end
      end
    end
  end

  // Reference model: inputs of the previous cycle decide the grant seen now
  logic          p_req [2];
  logic          p_wen [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  bit            m_last = 1, m_busy = 0, m_err = 0, m_we = 0, m_port = 0, md_seen = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0, md_val = '0;
  logic [DW-1:0] exp_rd [2];
  int            m_gnt_cyc = 0;
  int            mw;
  logic          st, st_prev = 1'b0;
  int            grant_log [$];
  logic [AW-1:0] wr_log [$];

  always @(negedge clk) begin
    st = mem_ren | mem_wen;
    if (!rst_n) begin
      m_last = 1; m_busy = 0; m_err = 0; md_seen = 0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      st_prev = 1'b0;
    end else begin
      chk("ren_wen_excl", 128'(mem_ren & mem_wen), 128'(0));
      if (gnt != 2'b00) begin
        mw = gnt[1] ? 1 : 0;
        chk("gnt_onehot", 128'($countones(gnt)), 128'(1));
        chk("gnt_while_busy", 128'(m_busy), 128'(0));
        chk("gnt_had_req", 128'(p_req[mw]), 128'(1));
        if (p_req[0] && p_req[1]) chk("gnt_round_robin", 128'(mw), 128'(!m_last));
        m_last = mw[0]; m_port = mw[0]; m_busy = 1;
        m_we = p_wen[mw]; m_addr = p_addr[mw]; m_data = p_wdata[mw];
        m_gnt_cyc = cyc;
        grant_log.push_back(mw);
      end
      if (st && !st_prev) begin
        chk("strobe_latency", 128'(cyc - m_gnt_cyc), 128'(1));
        chk("strobe_op", 128'(mem_wen), 128'(m_we));
        if (m_we) wr_log.push_back(mem_addr);
      end
      if (st) begin
        chk("mem_addr", 128'(mem_addr), 128'(m_addr));
        if (m_we) chk("mem_din", mem_din, m_data);
      end
      if (md_seen) chk("done_after_mem_done", 128'(done), 128'(m_port ? 2'b10 : 2'b01));
      if (done != 2'b00) begin
        chk("done_busy", 128'(m_busy), 128'(1));
        chk("done_port", 128'(done), 128'(m_port ? 2'b10 : 2'b01));
        chk("done_strobe_low", 128'(st), 128'(0));
        if (md_seen) begin
          if (!m_we) exp_rd[m_port] = md_val;
        end else begin
          chk("timeout_cycle", 128'(cyc - m_gnt_cyc), 128'(TB_TO + 1));
          m_err = 1;
        end
        m_busy = 0;
      end
      chk("timeout_err", 128'(err), 128'(m_err));
      chk("rdata0", rdata0, exp_rd[0]);
      chk("rdata1", rdata1, exp_rd[1]);
      md_seen = mem_done && st && m_busy;
      md_val  = mem_dout;
      st_prev = st;
    end
    p_req = req; p_wen = wen; p_addr = addr; p_wdata = wdata;
  end

  task automatic wait_gnt(input int p);
    int k = 0;
    while (!gnt[p] && k < LIM) begin @(posedge clk); #1; k++; end
    chk("gnt_arrives", 128'(gnt[p]), 128'(1));
  endtask

  task automatic wait_done(input int p);
    int k = 0;
    while (!done[p] && k < LIM) begin @(posedge clk); #1; k++; end
    chk("done_arrives", 128'(done[p]), 128'(1));
  endtask

  // Called at posedge+1; leaves req high through the done cycle, drops it after
  task automatic access(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p] = 1'b1; wen[p] = we; addr[p] = a; wdata[p] = d;
    wait_gnt(p);
    addr[p]  = AW'($urandom);
    wdata[p] = {$urandom, $urandom, $urandom, $urandom};
    wen[p]   = 1'($urandom_range(0, 1));
    wait_done(p);
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic agent(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      access(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
             {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ren"},   128'(mem_ren), 128'(0));
    chk({tag, "_wen"},   128'(mem_wen), 128'(0));
    chk({tag, "_addr"},  128'(mem_addr), 128'(0));
    chk({tag, "_din"},   mem_din, 128'(0));
    chk({tag, "_gnt"},   128'(gnt), 128'(0));
    chk({tag, "_done"},  128'(done), 128'(0));
    chk({tag, "_rdata0"}, rdata0, 128'(0));
    chk({tag, "_rdata1"}, rdata1, 128'(0));
    chk({tag, "_err"},   128'(err), 128'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    req[0] = 1'b1; wen[0] = 1'b0; addr[0] = 16'h0004; wdata[0] = '0;
    req[1] = 1'b0; wen[1] = 1'b0; addr[1] = '0;       wdata[1] = '0;
    lat_fixed = 100;
    dmem[16'h0004] = 128'hA5;

    // reset with a request pending, then a long read
    repeat (3) @(posedge clk); #1;
    chk_reset_outs("rst");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_gnt", 128'(gnt), 128'(2'b01));
    @(posedge clk); #1;
    chk("read_ren", 128'(mem_ren), 128'(1));
    chk("read_addr", 128'(mem_addr), 128'(16'h0004));
    wait_done(0);
    chk("read_rdata", rdata0, 128'hA5);
    chk("read_ren_low_at_done", 128'(mem_ren), 128'(0));
    @(posedge clk); #1; req[0] = 1'b0;

    // contention from reset: strict alternation
    lat_fixed = 2;
    do_reset();
    base = grant_log.size();
    fork
      begin access(0, 1'b0, 16'h0010, '0);    access(0, 1'b0, 16'h0011, '0);    end
      begin access(1, 1'b1, 16'h001F, 128'h1); access(1, 1'b1, 16'h0020, 128'h2); end
    join
    chk("contend_count", 128'(grant_log.size() - base), 128'(4));
    for (int i = 0; i < 4; i++) chk("contend_order", 128'(grant_log[base + i]), 128'(i % 2));
    chk("contend_p1_write", dmem[16'h001F], 128'h1);

    // back-to-back writes from port 1
    base = wr_log.size();
    for (int i = 0; i < 32; i++) access(1, 1'b1, AW'(i), DW'(i + 1));
    chk("b2b_count", 128'(wr_log.size() - base), 128'(32));
    for (int i = 0; i < 32; i++) chk("b2b_order", 128'(wr_log[base + i]), 128'(i));
    chk("b2b_last_data", dmem[16'h001F], 128'h20);

    // timeout: rdata held, error sticky, next access still served
    dmem[16'h0004] = 128'hA5;
    access(0, 1'b0, 16'h0004, '0);
    never_done = 1;
    access(0, 1'b0, 16'h0005, '0);
    chk("to_rdata_kept", rdata0, 128'hA5);
    chk("to_err_set", 128'(err), 128'(1));
    never_done = 0;
    access(1, 1'b0, 16'h0004, '0);
    chk("to_err_sticky", 128'(err), 128'(1));
    chk("to_next_served", rdata1, 128'hA5);

    // randomized traffic on both ports
    rand_lat = 1; rand_ready = 1;
    fork
      agent(0, 40);
      agent(1, 40);
    join
    rand_lat = 0; rand_ready = 0;
    repeat (2) begin @(posedge clk); #1; end

    // reset during an access
    lat_fixed = 50;
    req[0] = 1'b1; wen[0] = 1'b0; addr[0] = 16'h0008;
    begin
      int k = 0;
      while (!mem_ren && k < LIM) begin @(posedge clk); #1; k++; end
    end
    chk("mid_ren_high", 128'(mem_ren), 128'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 chk("mid_ren_async_low", 128'(mem_ren), 128'(0));
    req[1] = 1'b1; wen[1] = 1'b1; addr[1] = 16'h0009; wdata[1] = 128'h7;
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outs("mid_rst");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_regrant_p0", 128'(gnt), 128'(2'b01));
    wait_done(0);
    @(posedge clk); #1; req[0] = 1'b0;
    wait_gnt(1);
    wait_done(1);
    @(posedge clk); #1; req[1] = 1'b0;
    chk("mid_p1_write", dmem[16'h0009], 128'h7);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
